// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory read feeding a single registered decode slot.
// Define FETCH_SEQUENCER_PERF_EN to build the saturating perf_fetched/perf_bubbles counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    output logic [31:0] if_instr,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_target;
    logic        slot_free;
    logic        req_accept;
    logic        slot_load;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign slot_free       = !if_valid || !stall_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                // A redirect on the accept cycle still owes us a response for the old address.
                if (req_accept) begin
                    state_next = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = S_REQ;
                end else if (redirect_valid) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_rsp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        mem_req_valid = (state == S_REQ) && slot_free;
        mem_req_addr  = fetch_pc;
        req_accept    = mem_req_valid && mem_req_ready;
        slot_load     = (state == S_WAIT) && mem_rsp_valid && !redirect_valid;
    end

    // NOTE: the slot payload is reset too, so decode never observes X contents after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_pc_plus_4 <= 32'h0;
            if_instr     <= 32'h0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if (slot_load) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            // Redirect wins over both a fresh response and a stalled slot.
            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (slot_load) begin
                if_valid     <= 1'b1;
                if_pc        <= fetch_pc;
                if_pc_plus_4 <= fetch_pc + 32'd4;
                if_instr     <= mem_rsp_data;
            end else if (if_valid && !stall_d) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_SEQUENCER_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= 32'h0;
            bubbles_q <= 32'h0;
        end else begin
            if (slot_load && (fetched_q != 32'hFFFF_FFFF)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (!if_valid && (bubbles_q != 32'hFFFF_FFFF)) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (RESET_PC = 0x100); memory is driven cycle by cycle.
// Expected perf counter values depend on whether FETCH_SEQUENCER_PERF_EN is defined.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instr;
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_instr       (if_instr),
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
    );

    always #5 clk = ~clk;

`ifdef FETCH_SEQUENCER_PERF_EN
    localparam logic [31:0] EXP_FETCHED = 32'd5;
    localparam logic [31:0] EXP_BUBBLES = 32'd21;
`else
    localparam logic [31:0] EXP_FETCHED = 32'd0;
    localparam logic [31:0] EXP_BUBBLES = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance to 1 ns past the next rising edge.
    task automatic step(input string tag,
                        input logic rv, input logic [31:0] rpc, input logic st,
                        input logic rdy, input logic rspv, input logic [31:0] rdata,
                        input logic req_v, input logic [31:0] req_a,
                        input logic slot_v, input logic [31:0] slot_pc, input logic [31:0] slot_instr);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall_d        = st;
        mem_req_ready  = rdy;
        mem_rsp_valid  = rspv;
        mem_rsp_data   = rdata;
        #1;
        check({tag, "_req_valid"}, {31'h0, mem_req_valid}, {31'h0, req_v});
        if (req_v) check({tag, "_req_addr"}, mem_req_addr, req_a);
        check({tag, "_if_valid"}, {31'h0, if_valid}, {31'h0, slot_v});
        if (slot_v) begin
            check({tag, "_if_pc"}, if_pc, slot_pc);
            check({tag, "_if_pc4"}, if_pc_plus_4, slot_pc + 32'd4);
            check({tag, "_if_instr"}, if_instr, slot_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_if_valid"}, {31'h0, if_valid}, 32'h0);
        check({tag, "_if_pc"}, if_pc, 32'h0);
        check({tag, "_if_pc4"}, if_pc_plus_4, 32'h0);
        check({tag, "_if_instr"}, if_instr, 32'h0);
        check({tag, "_perf_fetched"}, perf_fetched, 32'h0);
        check({tag, "_perf_bubbles"}, perf_bubbles, 32'h0);
        check({tag, "_req_valid"}, {31'h0, mem_req_valid}, 32'h1);
        check({tag, "_req_addr"}, mem_req_addr, 32'h0000_0100);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall_d        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // Streaming fetch with 1-cycle responses: 0x100, 0x104 on alternate cycles.
        //       tag    rv  rpc            st    rdy   rspv  rdata          reqv  reqa           sv    spc            sinstr
        step("c00", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0);
        step("c01", 0, 32'h0,        0, 1, 1, 32'hA000_0100, 0, 32'h0,        0, 32'h0,        32'h0);
        step("c02", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h0000_0100, 32'hA000_0100);
        step("c03", 0, 32'h0,        0, 1, 1, 32'hA000_0104, 0, 32'h0,        0, 32'h0,        32'h0);
        // Slot 0x104 held under stall for 3 cycles with no request.
        step("c04", 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0104, 32'hA000_0104);
        step("c05", 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0104, 32'hA000_0104);
        step("c06", 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0104, 32'hA000_0104);
        step("c07", 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_0108, 1, 32'h0000_0104, 32'hA000_0104);
        // Redirect to 0x203 on acceptance of 0x108: drain, drop data, refetch at 0x200.
        step("c08", 1, 32'h0000_0203, 0, 1, 0, 32'h0,        1, 32'h0000_0108, 0, 32'h0,        32'h0);
        step("c09", 0, 32'h0,        0, 1, 1, 32'hA000_0108, 0, 32'h0,        0, 32'h0,        32'h0);
        step("c10", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0200, 0, 32'h0,        32'h0);
        // Redirect in WAIT, response two cycles later is discarded.
        step("c11", 1, 32'h0000_0300, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        step("c12", 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        step("c13", 0, 32'h0,        0, 1, 1, 32'hA000_0200, 0, 32'h0,        0, 32'h0,        32'h0);
        step("c14", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0300, 0, 32'h0,        32'h0);
        // Redirect in WAIT coinciding with the response: discard, straight back to REQ.
        step("c15", 1, 32'hFFFF_FFFC, 0, 1, 1, 32'hA000_0300, 0, 32'h0,        0, 32'h0,        32'h0);
        step("c16", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
        step("c17", 0, 32'h0,        0, 1, 1, 32'hAFFF_FFFC, 0, 32'h0,        0, 32'h0,        32'h0);
        // Wrap: if_pc_plus_4 = 0 and next request at 0; redirect in REQ without acceptance.
        step("c18", 1, 32'h0000_0400, 0, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hAFFF_FFFC);
        step("c19", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0400, 0, 32'h0,        32'h0);
        // Chained redirects while draining; the last lands with the response.
        step("c20", 1, 32'h0000_0500, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        step("c21", 1, 32'h0000_0600, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        step("c22", 1, 32'h0000_0700, 0, 1, 1, 32'hA000_0400, 0, 32'h0,        0, 32'h0,        32'h0);
        step("c23", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0700, 0, 32'h0,        32'h0);
        step("c24", 0, 32'h0,        0, 1, 1, 32'hA000_0700, 0, 32'h0,        0, 32'h0,        32'h0);
        // Redirect overrides a stalled slot.
        step("c25", 1, 32'h0000_0800, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0700, 32'hA000_0700);
        step("c26", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0800, 0, 32'h0,        32'h0);
        step("c27", 0, 32'h0,        0, 1, 1, 32'hA000_0800, 0, 32'h0,        0, 32'h0,        32'h0);
        step("c28", 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_0804, 1, 32'h0000_0800, 32'hA000_0800);

        // 29 counted edges: 8 with a valid slot, 5 slot loads.
        check("perf_fetched", perf_fetched, EXP_FETCHED);
        check("perf_bubbles", perf_bubbles, EXP_BUBBLES);

        step("c29", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0804, 0, 32'h0,        32'h0);

        // Asynchronous reset while 0x804 is outstanding.
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        reset          = 1'b1;
        #1;
        check_reset_state("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Stale response in REQ is ignored; fetch restarts at RESET_PC.
        step("r00", 0, 32'h0,        0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0000_0100, 0, 32'h0,        32'h0);
        step("r01", 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0);
        step("r02", 0, 32'h0,        0, 1, 1, 32'hA000_0100, 0, 32'h0,        0, 32'h0,        32'h0);
        step("r03", 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h0000_0100, 32'hA000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high.
REQ-004 redirect_valid  input  1  SHALL mean a branch or jump was taken; fetch continues at redirect_pc.
REQ-005 redirect_pc  input  32  SHALL be the redirect target; bits [1:0] are forced to 0 internally.
REQ-006 stall_d  input  1  SHALL mean decode cannot accept the instruction this cycle.
REQ-007 mem_req_valid  output  1  SHALL be the instruction-memory read request.
REQ-008 mem_req_addr  output  32  SHALL be the byte address of the request.
REQ-009 mem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-010 mem_rsp_valid  input  1  SHALL mean mem_rsp_data holds read data.
REQ-011 mem_rsp_data  input  32  SHALL be the instruction word.
REQ-012 if_valid, if_pc, if_pc_plus_4, if_instr  output  1/32/32/32  SHALL be the registered fetch slot presented to decode.
REQ-013 perf_fetched, perf_bubbles  output  32/32  SHALL be the performance counters (REQ-034).

Function
REQ-014 States: REQ, WAIT, DRAIN; at most one memory request outstanding.
REQ-015 Internal fetch_pc holds the next address to fetch; mem_req_addr SHALL equal fetch_pc.
REQ-016 Slot consumed when if_valid=1 and stall_d=0; slot free when if_valid=0 or consumed.
REQ-017 REQ: mem_req_valid=1 iff slot free; on valid&ready, go to WAIT.
REQ-018 mem_req_valid SHALL be 0 in WAIT and DRAIN.
REQ-019 Memory SHALL NOT return a response before the cycle after acceptance; mem_rsp_valid SHALL be ignored in REQ.
REQ-020 WAIT, mem_rsp_valid=1, no redirect: next cycle if_valid=1, if_pc=fetch_pc, if_pc_plus_4=fetch_pc+4, if_instr=mem_rsp_data; fetch_pc+=4; go to REQ.
REQ-021 Slot consumed with no new response: if_valid SHALL clear next cycle; if_valid=1 with stall_d=1: slot contents SHALL hold unchanged.
REQ-022 Redirect (any state) SHALL clear if_valid next cycle and load fetch_pc with redirect_pc; redirect overrides stall_d.
REQ-023 Redirect in REQ without acceptance: stay in REQ; next request uses the new address.
REQ-024 Redirect in REQ coinciding with acceptance: request is for the old address; go to DRAIN.
REQ-025 Redirect in WAIT without response: go to DRAIN.
REQ-026 Redirect in WAIT with mem_rsp_valid: discard response, go to REQ.
REQ-027 DRAIN: on mem_rsp_valid discard data and go to REQ; a further redirect in DRAIN updates fetch_pc and stays in DRAIN unless the response arrives in the same cycle.
REQ-028 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 Latency: acceptance at cycle N, response at N+k (k>=1), if_valid at N+k+1; the next request can issue at N+k+1.

Reset
REQ-030 Reset SHALL force state REQ, fetch_pc=RESET_PC, if_valid=0, if_pc=0, if_pc_plus_4=0, if_instr=0, perf counters 0.
REQ-031 mem_req_valid SHALL be 1 in the first cycle after reset deassertion, with address RESET_PC.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request; memory is reset in the same domain.

Configuration
REQ-033 Macro FETCH_SEQUENCER_PERF_EN SHALL gate the performance counters.
REQ-034 Defined: perf_fetched increments on each slot load (REQ-020); perf_bubbles increments each cycle if_valid=0; both saturate at 32'hFFFF_FFFF. Undefined: both outputs SHALL be tied to 0 and no counter logic exists.

Verification
REQ-035 Reset, RESET_PC=0x100, ready=1, 1-cycle response, stall_d=0 -> requests 0x100, 0x104, 0x108 on alternate cycles; if_pc matches; if_pc_plus_4=if_pc+4.
REQ-036 if_valid=1 with if_pc=0x104, stall_d=1 for 3 cycles -> slot held 3 cycles, mem_req_valid=0, no new acceptance.
REQ-037 Redirect to 0x200 in WAIT, response 2 cycles later -> response discarded, if_valid=0, next request address 0x200.
REQ-038 Redirect to 0x203 coinciding with acceptance of 0x108 -> DRAIN, 0x108 data dropped, next request 0x200.
REQ-039 fetch_pc=0xFFFF_FFFC, response arrives -> if_pc_plus_4=0, next request address 0.
REQ-040 With FETCH_SEQUENCER_PERF_EN, 10 delivered instructions and 7 empty cycles -> perf_fetched=10, perf_bubbles=7; without the macro -> both 0.
